// File: rtl/mips_irq_pkg.sv
// Shared types and constants for the MIPS interrupt controller.
// Holds the sequencer state encoding, the vector defaults and the source priority encoder.
package mips_irq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    VECTOR,
    ISR,
    RETURN
  } irq_state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0080;
  localparam int          VEC_STRIDE_DEF = 8;

  // Index of the lowest set bit; index 0 has the highest priority.
  function automatic logic [2:0] prio_enc(input logic [7:0] vec);
    prio_enc = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) prio_enc = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus a history flop per interrupt line.
// rise_out is a one-cycle pulse for each synchronised rising edge.
module irq_sync_edge #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic [N-1:0] async_in,
  output logic [N-1:0] rise_out
);

  logic [N-1:0] s1, s2, s3;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_out = s2 & ~s3;

endmodule

// File: rtl/mips_irq_ctrl.sv
// Interrupt controller for the 5-stage MIPS pipeline: latches and masks requests,
// drains and flushes the pipeline, redirects to a per-source vector and returns on eret.
module mips_irq_ctrl
  import mips_irq_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic [N_SRC-1:0] pend_clr,
  input  logic             pipe_safe,
  input  logic [31:0]      resume_pc,
  input  logic             eret,
  output logic             stall_fetch,
  output logic             flush,
  output logic             pc_redirect_en,
  output logic [31:0]      pc_redirect,
  output logic [31:0]      epc,
  output logic [2:0]       cause,
  output logic             in_isr,
  output logic [N_SRC-1:0] pending
);

  irq_state_t       state;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] vec_clr;
  logic [N_SRC-1:0] pending_nxt;
  logic [7:0]       sel_onehot;
  logic [2:0]       sel;

  irq_sync_edge #(.N(N_SRC)) u_sync (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .async_in (irq_in),
    .rise_out (rise)
  );

  assign active = pending & mask;
  assign sel    = prio_enc(8'(active));

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    sel_onehot  = 8'd1 << sel;
    vec_clr     = '0;
    if (state == VECTOR) vec_clr = sel_onehot[N_SRC-1:0];
    // A fresh edge wins over any clear in the same cycle.
    pending_nxt = (pending & ~pend_clr & ~vec_clr) | rise;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= pending_nxt;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      epc   <= '0;
      cause <= '0;
    end else begin
      case (state)
        IDLE:    if (active != '0) state <= DRAIN;
        DRAIN: begin
          if (active == '0)   state <= IDLE;
          else if (pipe_safe) state <= VECTOR;
        end
        VECTOR: begin
          epc   <= resume_pc;
          cause <= sel;
          state <= ISR;
        end
        ISR:     if (eret) state <= RETURN;
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs: a pure decode of the state register.
  always_comb begin
    stall_fetch    = 1'b0;
    flush          = 1'b0;
    pc_redirect_en = 1'b0;
    pc_redirect    = '0;
    in_isr         = 1'b0;
    case (state)
      DRAIN: stall_fetch = 1'b1;
      VECTOR: begin
        stall_fetch    = 1'b1;
        flush          = 1'b1;
        pc_redirect_en = 1'b1;
        pc_redirect    = VEC_BASE + 32'(sel) * 32'(VEC_STRIDE);
      end
      ISR: in_isr = 1'b1;
      RETURN: begin
        flush          = 1'b1;
        pc_redirect_en = 1'b1;
        pc_redirect    = epc;
        in_isr         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_irq_ctrl.sv
// Directed bench for mips_irq_ctrl; inputs change 1ns after each rising edge
// and outputs are checked at the same point, clear of the active edge.
module tb_mips_irq_ctrl;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = '0;
  logic [3:0]  pend_clr = '0;
  logic        pipe_safe = 1'b0;
  logic [31:0] resume_pc = '0;
  logic        eret = 1'b0;
  logic        stall_fetch, flush, pc_redirect_en, in_isr;
  logic [31:0] pc_redirect, epc;
  logic [2:0]  cause;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  mips_irq_ctrl dut (
    .CLK            (CLK),
    .rst_n          (rst_n),
    .irq_in         (irq_in),
    .mask_we        (mask_we),
    .mask_wdata     (mask_wdata),
    .pend_clr       (pend_clr),
    .pipe_safe      (pipe_safe),
    .resume_pc      (resume_pc),
    .eret           (eret),
    .stall_fetch    (stall_fetch),
    .flush          (flush),
    .pc_redirect_en (pc_redirect_en),
    .pc_redirect    (pc_redirect),
    .epc            (epc),
    .cause          (cause),
    .in_isr         (in_isr),
    .pending        (pending)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  // Control outputs packed as {stall_fetch, flush, pc_redirect_en, in_isr}.
  function automatic logic [31:0] ctl();
    return {28'd0, stall_fetch, flush, pc_redirect_en, in_isr};
  endfunction

  initial begin
    // Reset state
    tick(2);
    check("rst_ctl", ctl(), 32'h0);
    check("rst_pend", {28'd0, pending}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ctl", ctl(), 32'h0);
    check("post_rst_epc", epc, 32'h0);

    // 1: single source, best-case latency, level held only sets pending once
    write_mask(4'b0001);
    pipe_safe = 1'b1;
    resume_pc = 32'h40;
    irq_in    = 4'b0001;
    tick(2);
    check("t1_pend_e2", {28'd0, pending}, 32'h0);
    tick();
    check("t1_pend_e3", {28'd0, pending}, 32'h1);
    check("t1_idle_ctl", ctl(), 32'h0);
    tick();
    check("t1_drain_ctl", ctl(), 32'b1000);
    tick();
    check("t1_vec_ctl", ctl(), 32'b1110);
    check("t1_vec_pc", pc_redirect, 32'h80);
    tick();
    check("t1_isr_ctl", ctl(), 32'b0001);
    check("t1_epc", epc, 32'h40);
    check("t1_cause", {29'd0, cause}, 32'd0);
    check("t1_pend_clr", {28'd0, pending}, 32'h0);
    tick(3);
    check("t1_level_once", {28'd0, pending}, 32'h0);
    irq_in = '0;
    eret   = 1'b1;
    tick();
    eret   = 1'b0;
    check("t1_ret_ctl", ctl(), 32'b0111);
    check("t1_ret_pc", pc_redirect, 32'h40);
    tick();
    check("t1_idle_again", ctl(), 32'h0);
    check("t1_idle_pc", pc_redirect, 32'h0);

    // 2: simultaneous sources 1 and 2, fixed priority, back-to-back service
    write_mask(4'b1111);
    resume_pc = 32'h100;
    irq_in    = 4'b0110;
    tick(3);
    check("t2_pend", {28'd0, pending}, 32'h6);
    irq_in = '0;
    tick(2);
    check("t2_vec_pc", pc_redirect, 32'h88);
    tick();
    check("t2_cause", {29'd0, cause}, 32'd1);
    check("t2_pend_left", {28'd0, pending}, 32'h4);
    resume_pc = 32'h200;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("t2_ret_pc", pc_redirect, 32'h100);
    tick();
    check("t2_idle_ctl", ctl(), 32'h0);
    tick();
    check("t2_drain_ctl", ctl(), 32'b1000);
    tick();
    check("t2_vec2_pc", pc_redirect, 32'h90);
    tick();
    check("t2_cause2", {29'd0, cause}, 32'd2);
    check("t2_epc2", epc, 32'h200);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();

    // 3: pipeline not safe holds DRAIN without flushing
    pipe_safe = 1'b0;
    resume_pc = 32'h250;
    irq_in    = 4'b0001;
    tick(4);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_ctl", ctl(), 32'b1000);
      tick();
    end
    pipe_safe = 1'b1;
    check("t3_hold_last", ctl(), 32'b1000);
    tick();
    check("t3_vec_ctl", ctl(), 32'b1110);
    check("t3_vec_pc", pc_redirect, 32'h80);
    tick();
    check("t3_epc", epc, 32'h250);
    irq_in = '0;
    eret   = 1'b1;
    tick();
    eret   = 1'b0;
    tick(3);

    // 4: software clears the only active source while draining
    pipe_safe = 1'b0;
    resume_pc = 32'h300;
    irq_in    = 4'b0001;
    tick(4);
    check("t4_drain_ctl", ctl(), 32'b1000);
    pend_clr = 4'b0001;
    tick();
    pend_clr = '0;
    check("t4_pend_clr", {28'd0, pending}, 32'h0);
    tick();
    check("t4_idle_ctl", ctl(), 32'h0);
    check("t4_no_pc", pc_redirect, 32'h0);
    check("t4_epc_kept", epc, 32'h250);
    tick(2);
    check("t4_stays_idle", ctl(), 32'h0);

    // 5: masked source latches pending, then unmasking starts the sequence
    irq_in = '0;
    write_mask(4'b0000);
    tick(2);
    irq_in = 4'b1000;
    tick(3);
    check("t5_pend", {28'd0, pending}, 32'h8);
    tick();
    check("t5_no_stall", ctl(), 32'h0);
    pipe_safe = 1'b1;
    write_mask(4'b1000);
    check("t5_wr_idle", ctl(), 32'h0);
    tick();
    check("t5_drain", ctl(), 32'b1000);
    tick();
    check("t5_vec_pc", pc_redirect, 32'h98);
    tick();
    check("t5_cause", {29'd0, cause}, 32'd3);
    check("t5_isr", ctl(), 32'b0001);

    // 6: asynchronous reset while in the handler
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", ctl(), 32'h0);
    check("t6_rst_pend", {28'd0, pending}, 32'h0);
    check("t6_rst_epc", epc, 32'h0);
    check("t6_rst_cause", {29'd0, cause}, 32'd0);
    tick();
    rst_n = 1'b1;
    eret  = 1'b1;
    tick();
    eret  = 1'b0;
    check("t6_eret_ignored", ctl(), 32'h0);
    tick(2);
    check("t6_repend", {28'd0, pending}, 32'h8);
    tick(2);
    check("t6_mask_zero", ctl(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
